// File: rtl/demux_1to16_capture.sv
// demux_1to16_capture
//   Registered 1:16 demultiplexer. Rebuilds a serial bit stream into an
//   N_OUT-bit word and pulses out_valid when the word is complete.
//
//   Build option: define DEMUX_EXT_SEL_EN to take the target bit index from
//   in_sel (random access). When it is undefined, the index is the running
//   count (LSB first) and in_sel is ignored. The port list is the same in
//   both builds.
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     start     in   begin a new frame (clears any partial capture)
//     in        in   serial data bit
//     in_valid  in   qualifies in / in_sel this cycle
//     in_sel    in   target bit index (random-access build only)
//     out       out  last completed word
//     out_valid out  one-cycle pulse, out updated this cycle
//     busy      out  frame being filled
//     sel_cnt   out  distinct bits captured in the current frame
module demux_1to16_capture #(
  parameter  int N_OUT = 16,
  parameter  int SEL_W = 4,
  // sel_cnt has to reach N_OUT itself, so it gets enough bits for that value.
  localparam int CNT_W = $clog2(N_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N_OUT-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] sel_cnt
);

  localparam int IDX_W = (SEL_W > CNT_W) ? SEL_W : CNT_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e           state_q, state_d;
  logic [N_OUT-1:0] shadow_q, shadow_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] idx;
  logic [N_OUT-1:0] idx_oh;
  logic             new_bit;

`ifdef DEMUX_EXT_SEL_EN
  assign idx = IDX_W'(in_sel);
`else
  assign idx = IDX_W'(cnt_q);
  logic unused_in_sel;
  assign unused_in_sel = ^in_sel;
`endif

  // One-hot target; an index at or beyond N_OUT shifts out to zero, so such
  // a bit touches nothing and is not counted.
  assign idx_oh  = N_OUT'(1) << idx;
  assign new_bit = |(idx_oh & ~mask_q);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          shadow_d = '0;
          mask_d   = '0;
          cnt_d    = '0;
        end
      end
      FILL: begin
        // start wins over a bit offered in the same cycle; that bit is lost.
        if (start) begin
          shadow_d = '0;
          mask_d   = '0;
          cnt_d    = '0;
        end else if (in_valid) begin
          shadow_d = (shadow_q & ~idx_oh) | ({N_OUT{in}} & idx_oh);
          mask_d   = mask_q | idx_oh;
          if (new_bit && cnt_q != CNT_W'(N_OUT)) cnt_d = cnt_q + 1'b1;
          // Completed word is loaded with the final bit so out is already
          // valid during the DONE cycle that raises out_valid.
          if (&mask_d) begin
            state_d = DONE;
            out_d   = shadow_d;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d  = FILL;
          shadow_d = '0;
          mask_d   = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == FILL);
  assign sel_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_1to16_capture.sv
module tb_demux_1to16_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_sel = 4'd0;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic [4:0]  sel_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is just a word being filled bit by bit.
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_word = '0;
  logic [15:0] m_out = '0;

  demux_1to16_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .in_valid(in_valid),
    .in_sel(in_sel), .out(out), .out_valid(out_valid), .busy(busy), .sel_cnt(sel_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_cnt = 0; m_word = '0; m_out = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
  task automatic step(input bit s, input bit b, input bit v);
    start = s; in = b; in_valid = v; in_sel = 4'(m_cnt);
    @(posedge clk);
    if (m_done) begin
      m_done = 0;
      if (s) begin m_active = 1; m_cnt = 0; m_word = '0; end
    end else if (!m_active) begin
      if (s) begin m_active = 1; m_cnt = 0; m_word = '0; end
    end else if (s) begin
      m_cnt = 0; m_word = '0;
    end else if (v) begin
      m_word[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 16) begin m_out = m_word; m_active = 0; m_done = 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 4;
    if (out !== 16'h0) begin n_bad++; $display("FAIL reset_out got %h want 0000", out); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (sel_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", sel_cnt); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_auto();
    logic [15:0] w = 16'h3f0a;
    step(1, 0, 0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL auto_busy got %b want 1", busy); end
    for (int i = 0; i < 16; i++) begin
      step(0, w[i], 1);
      n_cmp += 2;
      if (sel_cnt !== 5'(m_cnt)) begin n_bad++; $display("FAIL auto_cnt[%0d] got %0d want %0d", i, sel_cnt, m_cnt); end
      if (out_valid !== m_done) begin n_bad++; $display("FAIL auto_vld[%0d] got %b want %b", i, out_valid, m_done); end
    end
    n_cmp += 4;
    if (out !== 16'h3f0a) begin n_bad++; $display("FAIL auto_out got %h want 3f0a", out); end
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL auto_pulse got %b want 1", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_busy_done got %b want 0", busy); end
    if (sel_cnt !== 5'd16) begin n_bad++; $display("FAIL auto_cnt16 got %0d want 16", sel_cnt); end
    step(0, 0, 0);
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL auto_pulse_end got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_busy_after got %b want 0", busy); end
    if (out !== 16'h3f0a) begin n_bad++; $display("FAIL auto_hold got %h want 3f0a", out); end
  endtask

  task automatic test_gaps();
    logic [15:0] w = 16'h3f0a;
    int vld_seen = 0;
    step(1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, w[i/2], (i % 2) == 0);
      if (i % 2 == 0) vld_seen++;
      n_cmp++;
      if (sel_cnt !== 5'(vld_seen)) begin n_bad++; $display("FAIL gaps_cnt[%0d] got %0d want %0d", i, sel_cnt, vld_seen); end
      if (i == 30) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 16'h3f0a) begin
          n_bad++; $display("FAIL gaps_out got %h/%b want 3f0a/1", out, out_valid);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [15:0] w = 16'ha5c3;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1'($urandom), 1);
    n_cmp++;
    if (sel_cnt !== 5'd5) begin n_bad++; $display("FAIL restart_cnt5 got %0d want 5", sel_cnt); end
    step(1, 1, 1);
    n_cmp++;
    if (sel_cnt !== 5'd0) begin n_bad++; $display("FAIL restart_clear got %0d want 0", sel_cnt); end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_cmp++;
        if (out !== 16'h3f0a) begin n_bad++; $display("FAIL restart_prev got %h want 3f0a", out); end
      end
      step(0, w[i], 1);
    end
    n_cmp += 2;
    if (out !== 16'ha5c3) begin n_bad++; $display("FAIL restart_out got %h want a5c3", out); end
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL restart_vld got %b want 1", out_valid); end
    step(0, 0, 0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1);
      n_cmp += 4;
      if (out !== 16'ha5c3) begin n_bad++; $display("FAIL idle_out got %h want a5c3", out); end
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_vld got %b want 0", out_valid); end
      if (sel_cnt !== 5'd16) begin n_bad++; $display("FAIL idle_cnt got %0d want 16", sel_cnt); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
    end
  endtask

  task automatic test_reset_midframe();
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1'($urandom), 1);
    n_cmp++;
    if (sel_cnt !== 5'd7) begin n_bad++; $display("FAIL mid_cnt7 got %0d want 7", sel_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (out !== 16'h0) begin n_bad++; $display("FAIL mid_out got %h want 0000", out); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    if (sel_cnt !== 5'd0) begin n_bad++; $display("FAIL mid_cnt got %0d want 0", sel_cnt); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 30) == 0, 1'($urandom), ($urandom % 3) != 0);
      n_cmp++;
      if (out !== m_out || out_valid !== m_done || busy !== m_active || sel_cnt !== 5'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand[%0d] got out=%h v=%b b=%b c=%0d want out=%h v=%b b=%b c=%0d",
                 i, out, out_valid, busy, sel_cnt, m_out, m_done, m_active, m_cnt);
      end
    end
  endtask

`ifdef DEMUX_EXT_SEL_EN
  task automatic test_ext_sel();
    logic [15:0] w = 16'h3f0a;
    int seq [17] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 6, 5, 4, 3, 2, 1, 0};
    @(negedge clk); start = 1; in_valid = 0;
    @(negedge clk); start = 0;
    for (int i = 0; i < 17; i++) begin
      in_sel = 4'(seq[i]); in = w[seq[i]]; in_valid = 1;
      @(negedge clk);
      if (i == 10) begin
        n_cmp++;
        if (sel_cnt !== 5'd10) begin n_bad++; $display("FAIL ext_dup got %0d want 10", sel_cnt); end
      end
    end
    in_valid = 0;
    n_cmp += 3;
    if (out !== 16'h3f0a) begin n_bad++; $display("FAIL ext_out got %h want 3f0a", out); end
    if (sel_cnt !== 5'd16) begin n_bad++; $display("FAIL ext_cnt got %0d want 16", sel_cnt); end
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ext_vld got %b want 1", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ext_pulse got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_auto();
    test_gaps();
    test_restart();
    test_idle();
    test_reset_midframe();
    test_random();
`ifdef DEMUX_EXT_SEL_EN
    test_ext_sel();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
